// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller and its call front end.
package elevator_pkg;

   localparam int NUM_FLOORS_DEF = 16;

   typedef enum logic {
      OB_EMPTY,
      OB_FULL
   } ob_state_e;

   function automatic int floor_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rr_floor_arbiter.sv
// Combinational round-robin floor picker; search starts just above ptr_i.
module rr_floor_arbiter
   import elevator_pkg::*;
#(
   parameter  int NUM_FLOORS = NUM_FLOORS_DEF,
   localparam int FW         = floor_w(NUM_FLOORS)
) (
   input  logic [NUM_FLOORS-1:0] req_i,
   input  logic [FW-1:0]         ptr_i,
   output logic [FW-1:0]         grant_idx_o,
   output logic                  grant_valid_o
);

   logic [FW-1:0] idx;

   // Walk from lowest to highest priority so the nearest request wins.
   always_comb begin
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      idx           = '0;
      for (int k = NUM_FLOORS; k >= 1; k--) begin
         idx = ptr_i + FW'(k);
         if (req_i[idx]) begin
            grant_idx_o   = idx;
            grant_valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hall_call_collector.sv
// Hall/cab call collector: dedups presses, lights lamps, offers floors round-robin.
// Optional HALL_CALL_STALE_REISSUE_EN re-offers floors left unserved by a watchdog.
module hall_call_collector
   import elevator_pkg::*;
#(
   parameter  int NUM_FLOORS      = NUM_FLOORS_DEF,
   parameter  int REISSUE_TIMEOUT = 1024,
   localparam int FW              = floor_w(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] btn_in,
   input  logic                  served_valid,
   input  logic [FW-1:0]         served_floor,
   output logic                  valid_out,
   output logic [FW-1:0]         floor_out,
   input  logic                  ready_in,
   output logic [NUM_FLOORS-1:0] lamp_out
);

   logic [NUM_FLOORS-1:0] btn_q, pending_q, pending_d;
   logic [NUM_FLOORS-1:0] issued_q, issued_d;
   logic [NUM_FLOORS-1:0] rise, served_oh, offer_oh, elig;
   logic [FW-1:0]         ptr_q, ptr_d, floor_q, floor_d;
   logic [FW-1:0]         arb_ptr, pick;
   logic                  pick_v, hs, stale;
   ob_state_e             state_q, state_d;

   assign valid_out = (state_q == OB_FULL);
   assign floor_out = floor_q;
   assign lamp_out  = pending_q;

   assign hs        = valid_out & ready_in;
   assign rise      = btn_in & ~btn_q;
   assign served_oh = served_valid ? (NUM_FLOORS'(1) << served_floor) : '0;
   assign offer_oh  = valid_out ? (NUM_FLOORS'(1) << floor_q) : '0;
   assign elig      = pending_q & ~issued_q & ~offer_oh;
   // On accept the next pick already searches past the accepted floor.
   assign arb_ptr   = hs ? floor_q : ptr_q;

   assign pending_d = (pending_q | rise) & ~served_oh;
   assign issued_d  = ((stale ? '0 : issued_q)
                      | (hs ? offer_oh : '0)) & ~served_oh;

   rr_floor_arbiter #(
      .NUM_FLOORS(NUM_FLOORS)
   ) u_arb (
      .req_i        (elig),
      .ptr_i        (arb_ptr),
      .grant_idx_o  (pick),
      .grant_valid_o(pick_v)
   );

`ifdef HALL_CALL_STALE_REISSUE_EN
   localparam int WDW = $clog2(REISSUE_TIMEOUT + 1);

   logic [WDW-1:0] wd_q, wd_d;

   assign stale = (wd_q == WDW'(REISSUE_TIMEOUT));

   always_comb begin
      wd_d = wd_q + WDW'(1);
      if (served_valid || issued_q == '0 || stale) begin
         wd_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   assign stale = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      ptr_d   = hs ? floor_q : ptr_q;
      unique case (state_q)
         OB_EMPTY: begin
            if (pick_v) begin
               state_d = OB_FULL;
               floor_d = pick;
            end
         end
         OB_FULL: begin
            if (hs) begin
               if (pick_v) begin
                  floor_d = pick;
               end else begin
                  state_d = OB_EMPTY;
               end
            end
         end
         default: state_d = OB_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q     <= '0;
         pending_q <= '0;
         issued_q  <= '0;
         ptr_q     <= '1;
         floor_q   <= '0;
         state_q   <= OB_EMPTY;
      end else begin
         btn_q     <= btn_in;
         pending_q <= pending_d;
         issued_q  <= issued_d;
         ptr_q     <= ptr_d;
         floor_q   <= floor_d;
         state_q   <= state_d;
      end
   end

endmodule

// File: tb/tb_hall_call_collector.sv
// Scoreboard bench for hall_call_collector: directed presses, serves and stalls.
module tb_hall_call_collector;

   localparam int NF = 16;
   localparam int FW = 4;
`ifdef HALL_CALL_STALE_REISSUE_EN
   localparam int HOLD = 10;
`else
   localparam int HOLD = 50;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NF-1:0] btn_in = '0;
   logic          served_valid = 1'b0;
   logic [FW-1:0] served_floor = '0;
   logic          valid_out;
   logic [FW-1:0] floor_out;
   logic          ready_in = 1'b0;
   logic [NF-1:0] lamp_out;

   int errors = 0;
   int checks = 0;
   int sb[$];
   logic          stall_q = 1'b0;
   logic [FW-1:0] stall_floor = '0;

   hall_call_collector #(
      .NUM_FLOORS     (NF),
      .REISSUE_TIMEOUT(16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn_in),
      .served_valid(served_valid),
      .served_floor(served_floor),
      .valid_out   (valid_out),
      .floor_out   (floor_out),
      .ready_in    (ready_in),
      .lamp_out    (lamp_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget, input string nm);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk({nm, " drained"}, sb.size(), 0);
   endtask

   task automatic serve(input int f);
      served_valid = 1'b1;
      served_floor = FW'(f);
      tick();
      served_valid = 1'b0;
   endtask

   // Monitor: every accepted offer must match the scoreboard head;
   // a stalled offer must stay put.
   always @(negedge clk) begin
      if (reset) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            checks++;
            if (!valid_out || floor_out != stall_floor) begin
               errors++;
               $display("FAIL stall_hold: got v=%0b f=%0d expected v=1 f=%0d",
                        valid_out, floor_out, stall_floor);
            end
         end
         if (valid_out && ready_in) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL offer: got floor %0d expected no offer",
                        floor_out);
            end else begin
               int e;
               e = sb.pop_front();
               if (int'(floor_out) != e) begin
                  errors++;
                  $display("FAIL offer: got floor %0d expected %0d",
                           floor_out, e);
               end
            end
         end
         stall_q     = valid_out && !ready_in;
         stall_floor = floor_out;
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset and idle
      ready_in = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_valid", valid_out, 0);
      chk("rst_floor", floor_out, 0);
      chk("rst_lamp", lamp_out, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle", {valid_out, lamp_out}, 0);
      end

      // Single press held: one lamp, one offer
      btn_in[5] = 1'b1;
      sb.push_back(5);
      tick();
      chk("f5_lamp", lamp_out, 32'h0020);
      chk("f5_nvalid", valid_out, 0);
      tick();
      chk("f5_valid", valid_out, 1);
      chk("f5_floor", floor_out, 5);
      repeat (HOLD) tick();
      chk("f5_held_lamp", lamp_out, 32'h0020);
      chk("f5_no_repeat", valid_out, 0);
      serve(5);
      chk("f5_served", lamp_out, 0);
      btn_in = '0;

      // Fresh pointer, three presses during a stall
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ready_in = 1'b0;
      btn_in = 16'h1208;
      sb.push_back(3);
      sb.push_back(9);
      sb.push_back(12);
      tick();
      chk("multi_lamp", lamp_out, 32'h1208);
      tick();
      chk("stall_floor", floor_out, 3);
      repeat (10) tick();
      ready_in = 1'b1;
      drain(10, "multi");
      serve(3);
      serve(9);
      serve(12);
      chk("multi_clear", lamp_out, 0);
      btn_in = '0;

      // Serve coinciding with re-press
      btn_in[7] = 1'b1;
      sb.push_back(7);
      drain(6, "f7");
      btn_in[7] = 1'b0;
      tick();
      btn_in[7] = 1'b1;
      serve(7);
      chk("f7_clear", lamp_out[7], 0);
      repeat (5) tick();
      chk("f7_stays", lamp_out[7], 0);
      chk("f7_no_offer", valid_out, 0);
      btn_in = '0;

      // Wrap-around after 14
      ready_in = 1'b0;
      btn_in[14] = 1'b1;
      tick();
      tick();
      chk("f14_floor", floor_out, 14);
      btn_in[15] = 1'b1;
      btn_in[2]  = 1'b1;
      tick();
      tick();
      chk("wrap_lamp", lamp_out, 32'hC004);
      sb.push_back(14);
      sb.push_back(15);
      sb.push_back(2);
      ready_in = 1'b1;
      drain(8, "wrap");
      btn_in = '0;

      // Reset while an offer is outstanding
      ready_in = 1'b0;
      btn_in[1] = 1'b1;
      tick();
      tick();
      chk("pre_rst_valid", valid_out, 1);
      reset = 1'b1;
      ready_in = 1'b1;
      btn_in = '0;
      tick();
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_lamp", lamp_out, 0);
      reset = 1'b0;
      tick();
      chk("post_rst_valid", valid_out, 0);

      // Accepted floor never served
      btn_in[4] = 1'b1;
      sb.push_back(4);
      drain(6, "f4");
`ifdef HALL_CALL_STALE_REISSUE_EN
      sb.push_back(4);
      drain(40, "f4_reissue");
`else
      repeat (100) tick();
`endif
      chk("f4_lamp", lamp_out[4], 1);
      btn_in = '0;
      chk("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
